// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the memory-port round-robin arbiter.
//   - arb_state_e       : FSM state encoding (IDLE / WAIT / DONE)
//   - ARB_STATE_W       : width of the state register
//   - ARB_TIMEOUT_DEFAULT : default number of WAIT cycles before abort
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

   localparam int ARB_STATE_W         = 2;
   localparam int ARB_TIMEOUT_DEFAULT = 255;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// index ptr_i and wrapping past N_CPU-1, returning the first requester found.
// Ports:
//   req_i    in  N_CPU  pending requests (one bit per requester)
//   ptr_i    in  PTR_W  index that has highest priority this round
//   winner_o out N_CPU  one-hot winner (all zero when nothing pending)
//   valid_o  out 1      at least one request pending
// -----------------------------------------------------------------------------
module bus_arbiter_rr_pick #(
   parameter int N_CPU = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_CPU-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_CPU-1:0] winner_o,
   output logic             valid_o
);

   // Rotating priority scan; once a winner is found later hits are masked.
   always_comb begin
      int   idx;
      logic hit;
      winner_o = {N_CPU{1'b0}};
      valid_o  = 1'b0;
      idx      = 0;
      hit      = 1'b0;
      for (int k = 0; k < N_CPU; k++) begin
         idx           = (int'(ptr_i) + k) % N_CPU;
         hit           = ~valid_o & req_i[idx];
         winner_o[idx] = winner_o[idx] | hit;
         valid_o       = valid_o | hit;
      end
   end

endmodule : bus_arbiter_rr_pick

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one external memory port among N_CPU bus front-ends. One owner at a
// time; the owner's transaction is latched, forwarded to memory and completed
// with a one-cycle read_dn / write_dn / err pulse. Everyone else sees bus_busy.
// Ports:
//   clk, rst         clock / synchronous active-low reset
//   halt_q           blocks new grants (does not abort an ongoing transfer)
//   req_read_q/_write_q  per-requester read / write requests
//   req_addr/req_data    packed per-requester address / write data
//   grant, bus_busy      one-hot owner / "owned by someone else"
//   read_dn, write_dn, err  completion pulses to the owner
//   rd_data              read data, valid in the read_dn cycle, then held
//   mem_read_q/_write_q  memory strobes, held until done or timeout
//   mem_addr, mem_data_out  latched address / write data
//   mem_data_in, mem_read_dn, mem_write_dn  memory response
// -----------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int N_CPU   = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      halt_q,
   input  logic [N_CPU-1:0]          req_read_q,
   input  logic [N_CPU-1:0]          req_write_q,
   input  logic [N_CPU*ADDR_W-1:0]   req_addr,
   input  logic [N_CPU*DATA_W-1:0]   req_data,
   output logic [N_CPU-1:0]          grant,
   output logic [N_CPU-1:0]          bus_busy,
   output logic [N_CPU-1:0]          read_dn,
   output logic [N_CPU-1:0]          write_dn,
   output logic [N_CPU-1:0]          err,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      mem_read_q,
   output logic                      mem_write_q,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data_out,
   input  logic [DATA_W-1:0]         mem_data_in,
   input  logic                      mem_read_dn,
   input  logic                      mem_write_dn
);

   localparam int          PTR_W    = (N_CPU > 1) ? $clog2(N_CPU) : 1;
   // Last WAIT cycle index: the counter starts at 0 on the first WAIT cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   arb_state_e          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [N_CPU-1:0]    grant_q, grant_d;
   logic [N_CPU-1:0]    busy_q, busy_d;
   logic [N_CPU-1:0]    read_dn_q, read_dn_d;
   logic [N_CPU-1:0]    write_dn_q, write_dn_d;
   logic [N_CPU-1:0]    err_q, err_d;
   logic                is_read_q, is_read_d;
   logic                mem_rd_q, mem_rd_d;
   logic                mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic [N_CPU-1:0]    pend_s;
   logic [N_CPU-1:0]    pick_win_s;
   logic                pick_valid_s;
   logic [ADDR_W-1:0]   addr_sel_s;
   logic [DATA_W-1:0]   data_sel_s;
   logic [PTR_W-1:0]    ptr_nxt_s;
   logic                done_hit_s;

   // A requester is pending if it wants either a read or a write.
   assign pend_s = req_read_q | req_write_q;

   bus_arbiter_rr_pick #(
      .N_CPU (N_CPU),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_i    (pend_s),
      .ptr_i    (ptr_q),
      .winner_o (pick_win_s),
      .valid_o  (pick_valid_s)
   );

   // One-hot muxes for the winner's address/data and the owner's successor index.
   always_comb begin
      addr_sel_s = {ADDR_W{1'b0}};
      data_sel_s = {DATA_W{1'b0}};
      ptr_nxt_s  = {PTR_W{1'b0}};
      for (int i = 0; i < N_CPU; i++) begin
         addr_sel_s = addr_sel_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{pick_win_s[i]}});
         data_sel_s = data_sel_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{pick_win_s[i]}});
         ptr_nxt_s  = ptr_nxt_s | (grant_q[i] ? PTR_W'((i + 1) % N_CPU) : {PTR_W{1'b0}});
      end
   end

   // Next-state and next-output logic for the IDLE/WAIT/DONE sequencer.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      grant_d    = grant_q;
      is_read_d  = is_read_q;
      mem_rd_d   = mem_rd_q;
      mem_wr_d   = mem_wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      read_dn_d  = {N_CPU{1'b0}};
      write_dn_d = {N_CPU{1'b0}};
      err_d      = {N_CPU{1'b0}};
      // Only the dn matching the latched kind completes the transfer.
      done_hit_s = is_read_q ? mem_read_dn : mem_write_dn;

      case (state_q)
         ARB_IDLE: begin
            if (!halt_q && pick_valid_s) begin
               state_d   = ARB_WAIT;
               grant_d   = pick_win_s;
               // Read wins when a requester asks for both; its write stays pending.
               is_read_d = |(pick_win_s & req_read_q);
               mem_rd_d  = is_read_d;
               mem_wr_d  = ~is_read_d;
               addr_d    = addr_sel_s;
               wdata_d   = data_sel_s;
               cnt_d     = 16'd0;
            end else begin
               state_d   = ARB_IDLE;
            end
         end
         ARB_WAIT: begin
            if (done_hit_s) begin
               state_d  = ARB_DONE;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               if (is_read_q) begin
                  read_dn_d = grant_q;
                  rd_data_d = mem_data_in;
               end else begin
                  write_dn_d = grant_q;
               end
            end else if (cnt_q == TMO_LAST) begin
               state_d  = ARB_DONE;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               err_d    = grant_q;
            end else begin
               cnt_d    = cnt_q + 16'd1;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
            ptr_d   = ptr_nxt_s;
            grant_d = {N_CPU{1'b0}};
            cnt_d   = 16'd0;
         end
         default: begin
            state_d  = ARB_IDLE;
            grant_d  = {N_CPU{1'b0}};
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            cnt_d    = 16'd0;
         end
      endcase

      busy_d = (state_d != ARB_IDLE) ? ~grant_d : {N_CPU{1'b0}};
   end

   // State and output registers; reset clears everything and drops any transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= {PTR_W{1'b0}};
         cnt_q      <= 16'd0;
         grant_q    <= {N_CPU{1'b0}};
         busy_q     <= {N_CPU{1'b0}};
         read_dn_q  <= {N_CPU{1'b0}};
         write_dn_q <= {N_CPU{1'b0}};
         err_q      <= {N_CPU{1'b0}};
         is_read_q  <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         addr_q     <= {ADDR_W{1'b0}};
         wdata_q    <= {DATA_W{1'b0}};
         rd_data_q  <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         read_dn_q  <= read_dn_d;
         write_dn_q <= write_dn_d;
         err_q      <= err_d;
         is_read_q  <= is_read_d;
         mem_rd_q   <= mem_rd_d;
         mem_wr_q   <= mem_wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign grant        = grant_q;
   assign bus_busy     = busy_q;
   assign read_dn      = read_dn_q;
   assign write_dn     = write_dn_q;
   assign err          = err_q;
   assign rd_data      = rd_data_q;
   assign mem_read_q   = mem_rd_q;
   assign mem_write_q  = mem_wr_q;
   assign mem_addr     = addr_q;
   assign mem_data_out = wdata_q;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (N_CPU=4, 32-bit, TIMEOUT=8). Inputs change
// 1 time unit after each rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            halt_q;
   logic [N-1:0]    req_read_q, req_write_q;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    grant, bus_busy, read_dn, write_dn, err;
   logic [DW-1:0]   rd_data, mem_data_out, mem_data_in;
   logic [AW-1:0]   mem_addr;
   logic            mem_read_q, mem_write_q, mem_read_dn, mem_write_dn;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.N_CPU(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .halt_q(halt_q),
      .req_read_q(req_read_q), .req_write_q(req_write_q),
      .req_addr(req_addr), .req_data(req_data),
      .grant(grant), .bus_busy(bus_busy), .read_dn(read_dn), .write_dn(write_dn),
      .err(err), .rd_data(rd_data),
      .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out),
      .mem_data_in(mem_data_in), .mem_read_dn(mem_read_dn), .mem_write_dn(mem_write_dn)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      halt_q = 1'b0; req_read_q = '0; req_write_q = '0; req_addr = '0; req_data = '0;
      mem_data_in = '0; mem_read_dn = 1'b0; mem_write_dn = 1'b0;
      rst = 1'b0;
      tick(); tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", grant); end
      checks++; if (bus_busy !== 4'b0000) begin errors++; $display("FAIL rst_busy got=%b exp=0000", bus_busy); end
      checks++; if ({mem_read_q, mem_write_q} !== 2'b00) begin errors++; $display("FAIL rst_strobe got=%b exp=00", {mem_read_q, mem_write_q}); end
      checks++; if ({read_dn, write_dn, err} !== 12'h000) begin errors++; $display("FAIL rst_pulses got=%h exp=000", {read_dn, write_dn, err}); end
      checks++; if ({rd_data, mem_addr, mem_data_out} !== 96'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {rd_data, mem_addr, mem_data_out}); end
      rst = 1'b1;
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp_g;
      apply_reset();
      req_read_q = 4'b1111;
      mem_read_dn = 1'b1;
      for (int t = 0; t < 5; t++) begin
         exp_g = 4'b0001 << (t % 4);
         tick();                                   // WAIT
         mem_data_in = 32'hA000_0000 + 32'(t);
         checks++; if (grant !== exp_g) begin errors++; $display("FAIL fair_grant t=%0d got=%b exp=%b", t, grant, exp_g); end
         checks++; if (bus_busy !== ~exp_g) begin errors++; $display("FAIL fair_busy t=%0d got=%b exp=%b", t, bus_busy, ~exp_g); end
         tick();                                   // DONE
         checks++; if (read_dn !== exp_g) begin errors++; $display("FAIL fair_rdn t=%0d got=%b exp=%b", t, read_dn, exp_g); end
         checks++; if (rd_data !== 32'hA000_0000 + 32'(t)) begin errors++; $display("FAIL fair_rdata t=%0d got=%h exp=%h", t, rd_data, 32'hA000_0000 + 32'(t)); end
         if (t == 4) req_read_q = '0;
         tick();                                   // IDLE
         checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL fair_idle t=%0d got=%b exp=0000", t, grant); end
      end
      mem_read_dn = 1'b0;
   endtask

   task automatic test_single_read();
      // ptr is 1 here (last owner 0); requester 2 is the only one pending.
      req_addr[2*AW +: AW] = 32'h0000_0100;
      req_read_q = 4'b0100;
      tick();                                      // WAIT 1
      req_read_q = '0;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL sr_grant got=%b exp=0100", grant); end
      checks++; if ({mem_read_q, mem_write_q} !== 2'b10) begin errors++; $display("FAIL sr_strobe got=%b exp=10", {mem_read_q, mem_write_q}); end
      checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sr_addr got=%h exp=00000100", mem_addr); end
      checks++; if (bus_busy !== 4'b1011) begin errors++; $display("FAIL sr_busy got=%b exp=1011", bus_busy); end
      tick();                                      // WAIT 2
      checks++; if (mem_read_q !== 1'b1 || read_dn !== 4'b0000) begin errors++; $display("FAIL sr_hold got=%b/%b exp=1/0000", mem_read_q, read_dn); end
      tick();                                      // WAIT 3: memory answers
      mem_read_dn = 1'b1; mem_data_in = 32'hDEAD_BEEF;
      tick();                                      // DONE
      mem_read_dn = 1'b0; mem_data_in = 32'h0;
      checks++; if (read_dn !== 4'b0100) begin errors++; $display("FAIL sr_rdn got=%b exp=0100", read_dn); end
      checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rdata got=%h exp=deadbeef", rd_data); end
      checks++; if (mem_read_q !== 1'b0 || write_dn !== 4'b0000 || err !== 4'b0000) begin errors++; $display("FAIL sr_done got=%b/%b/%b exp=0/0000/0000", mem_read_q, write_dn, err); end
      tick();                                      // IDLE
      checks++; if (grant !== 4'b0000 || read_dn !== 4'b0000 || bus_busy !== 4'b0000) begin errors++; $display("FAIL sr_idle got=%b/%b/%b exp=0", grant, read_dn, bus_busy); end
      checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rdhold got=%h exp=deadbeef", rd_data); end
   endtask

   task automatic test_timeout();
      req_addr[1*AW +: AW] = 32'h0000_0200;
      req_data[1*DW +: DW] = 32'h1234_5678;
      req_write_q = 4'b0010;
      tick();                                      // WAIT 1
      req_write_q = '0;
      checks++; if (grant !== 4'b0010 || mem_write_q !== 1'b1) begin errors++; $display("FAIL to_grant got=%b/%b exp=0010/1", grant, mem_write_q); end
      checks++; if (mem_data_out !== 32'h1234_5678) begin errors++; $display("FAIL to_wdata got=%h exp=12345678", mem_data_out); end
      for (int k = 2; k <= 8; k++) begin
         tick();
         checks++; if (mem_write_q !== 1'b1 || err !== 4'b0000) begin errors++; $display("FAIL to_hold cyc=%0d got=%b/%b exp=1/0000", k, mem_write_q, err); end
      end
      tick();                                      // DONE (aborted)
      checks++; if (mem_write_q !== 1'b0) begin errors++; $display("FAIL to_drop got=%b exp=0", mem_write_q); end
      checks++; if (err !== 4'b0010) begin errors++; $display("FAIL to_err got=%b exp=0010", err); end
      checks++; if (write_dn !== 4'b0000) begin errors++; $display("FAIL to_wdn got=%b exp=0000", write_dn); end
      tick();                                      // IDLE
      checks++; if (err !== 4'b0000 || grant !== 4'b0000) begin errors++; $display("FAIL to_idle got=%b/%b exp=0000/0000", err, grant); end
   endtask

   task automatic test_halt();
      halt_q = 1'b1;
      req_addr[3*AW +: AW] = 32'h0000_0300;
      req_data[3*DW +: DW] = 32'hCAFE_F00D;
      req_write_q = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++; if (grant !== 4'b0000 || mem_write_q !== 1'b0) begin errors++; $display("FAIL halt_block cyc=%0d got=%b/%b exp=0000/0", k, grant, mem_write_q); end
      end
      halt_q = 1'b0;
      tick();                                      // WAIT
      req_write_q = '0;
      checks++; if (grant !== 4'b1000 || mem_write_q !== 1'b1) begin errors++; $display("FAIL halt_grant got=%b/%b exp=1000/1", grant, mem_write_q); end
      checks++; if (mem_data_out !== 32'hCAFE_F00D || mem_addr !== 32'h0000_0300) begin errors++; $display("FAIL halt_latch got=%h/%h exp=cafef00d/00000300", mem_data_out, mem_addr); end
      // Halt raised mid-transfer must not abort it.
      halt_q = 1'b1; mem_write_dn = 1'b1;
      tick();                                      // DONE
      mem_write_dn = 1'b0; halt_q = 1'b0;
      checks++; if (write_dn !== 4'b1000 || read_dn !== 4'b0000) begin errors++; $display("FAIL halt_wdn got=%b/%b exp=1000/0000", write_dn, read_dn); end
      tick();                                      // IDLE
   endtask

   task automatic test_both();
      req_addr[0 +: AW] = 32'h0000_0040;
      req_read_q = 4'b0001; req_write_q = 4'b0001;
      tick();                                      // WAIT (read)
      checks++; if (grant !== 4'b0001 || {mem_read_q, mem_write_q} !== 2'b10) begin errors++; $display("FAIL both_read got=%b/%b exp=0001/10", grant, {mem_read_q, mem_write_q}); end
      mem_read_dn = 1'b1; mem_data_in = 32'h5555_AAAA;
      tick();                                      // DONE
      mem_read_dn = 1'b0;
      req_read_q = '0;
      checks++; if (read_dn !== 4'b0001 || write_dn !== 4'b0000) begin errors++; $display("FAIL both_rdn got=%b/%b exp=0001/0000", read_dn, write_dn); end
      tick();                                      // IDLE
      tick();                                      // WAIT (write)
      checks++; if (grant !== 4'b0001 || {mem_read_q, mem_write_q} !== 2'b01) begin errors++; $display("FAIL both_write got=%b/%b exp=0001/01", grant, {mem_read_q, mem_write_q}); end
      req_write_q = '0;
      mem_read_dn = 1'b1;                          // wrong kind of done
      tick();
      mem_read_dn = 1'b0;
      checks++; if (mem_write_q !== 1'b1 || write_dn !== 4'b0000 || read_dn !== 4'b0000) begin errors++; $display("FAIL both_nomatch got=%b/%b/%b exp=1/0000/0000", mem_write_q, write_dn, read_dn); end
      mem_write_dn = 1'b1;
      tick();                                      // DONE
      mem_write_dn = 1'b0;
      checks++; if (write_dn !== 4'b0001) begin errors++; $display("FAIL both_wdn got=%b exp=0001", write_dn); end
      checks++; if (rd_data !== 32'h5555_AAAA) begin errors++; $display("FAIL both_rdhold got=%h exp=5555aaaa", rd_data); end
      tick();                                      // IDLE
   endtask

   task automatic test_reset_mid();
      // ptr is 1 here; requester 2 wins alone.
      req_read_q = 4'b0100;
      tick();                                      // WAIT
      req_read_q = '0;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rm_grant got=%b exp=0100", grant); end
      rst = 1'b0; mem_read_dn = 1'b1; mem_data_in = 32'h7777_7777;
      tick();
      rst = 1'b1; mem_read_dn = 1'b0;
      checks++; if (grant !== 4'b0000 || {mem_read_q, mem_write_q} !== 2'b00 || bus_busy !== 4'b0000) begin errors++; $display("FAIL rm_clear got=%b/%b/%b exp=0", grant, {mem_read_q, mem_write_q}, bus_busy); end
      checks++; if ({read_dn, write_dn, err} !== 12'h000 || rd_data !== 32'h0) begin errors++; $display("FAIL rm_pulse got=%h/%h exp=0", {read_dn, write_dn, err}, rd_data); end
      tick();
      checks++; if ({read_dn, err} !== 8'h00) begin errors++; $display("FAIL rm_nodn got=%h exp=00", {read_dn, err}); end
      // Pointer back at 0: with everyone asking, requester 0 must win.
      req_read_q = 4'b1111;
      tick();
      req_read_q = '0;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", grant); end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_read();
      test_timeout();
      test_halt();
      test_both();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bus_arbiter

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares one external memory port among N_CPU internal-bus instances. Each instance raises read_q/write_q with an address (and data for writes). The arbiter grants one requester at a time and forwards the transaction to memory. It returns the done pulse and read data to the owner and signals bus_busy to all other requesters. It sits between the per-core bus front-ends and the memory/dispatcher port.

Parameters:
N_CPU, 4, number of requesters (2..8)
ADDR_W, 32, address width (matches ADDR_SIZE)
DATA_W, 32, data width (matches DATA_SIZE)
TIMEOUT, 255, max cycles waiting for memory done before abort (1..65535)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-low
halt_q  in  1  global halt: no new grants while high
req_read_q  in  N_CPU  per-requester read request
req_write_q  in  N_CPU  per-requester write request
req_addr  in  N_CPU*ADDR_W  per-requester address, slice i = requester i
req_data  in  N_CPU*DATA_W  per-requester write data
grant  out  N_CPU  one-hot owner of the memory port
bus_busy  out  N_CPU  bus owned by another requester
read_dn  out  N_CPU  one-cycle read-complete pulse to owner
write_dn  out  N_CPU  one-cycle write-complete pulse to owner
err  out  N_CPU  one-cycle timeout pulse to owner
rd_data  out  DATA_W  read data, valid in the read_dn cycle
mem_read_q  out  1  memory read strobe, held until done
mem_write_q  out  1  memory write strobe, held until done
mem_addr  out  ADDR_W  latched address of current transaction
mem_data_out  out  DATA_W  latched write data
mem_data_in  in  DATA_W  memory read data
mem_read_dn  in  1  memory read done
mem_write_dn  in  1  memory write done

Behaviour:
- Reset: rst low at a posedge clears all outputs to 0, sets state IDLE, rr pointer 0, timeout counter 0. Reset mid-transaction aborts it silently: no dn and no err.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if halt_q is 0 and any request is pending, pick the winner round-robin starting at index ptr. Latch addr/data/kind and the one-hot grant, assert mem_read_q or mem_write_q, go to WAIT. Grant and strobe appear on the cycle after the request is seen (latency 1).
- A requester asserting both read_q and write_q is serviced as a read. The write stays pending for a later arbitration.
- WAIT: strobe, addr and data are held stable. On a matching mem_*_dn: drop the strobe, capture mem_data_in into rd_data (reads), go to DONE. A non-matching dn is ignored.
- Timeout: the counter increments each WAIT cycle. When it reaches TIMEOUT without a matching dn, drop the strobe and go to DONE with the abort flag set.
- DONE (one cycle): pulse read_dn[i], write_dn[i] or err[i] for the owner. Set ptr = (owner+1) mod N_CPU, clear grant and the counter, return to IDLE.
- Earliest next grant is the cycle after DONE. Back-to-back minimum transaction is 3 cycles when memory answers the first WAIT cycle.
- bus_busy[j] = 1 when state is not IDLE and grant[j] = 0. bus_busy[owner] = 0.
- Requests withdrawn during WAIT do not cancel the transaction. Completion pulses are still issued.
- halt_q asserted during WAIT does not abort. It only blocks the next grant.
- Outputs other than grant, strobes and pulses hold their last value when IDLE. rd_data holds until the next read completes.
- Round-robin wraps from N_CPU-1 to 0. With a single persistent requester, it is re-granted every transaction.

Decomposition:
- Shared package/include (next to states.v): FSM state encodings ARB_IDLE/ARB_WAIT/ARB_DONE, state width, default TIMEOUT constant.
- One sub-module rr_pick: combinational round-robin selector. Inputs are the request vector and ptr; outputs are a one-hot winner and a valid flag. Instantiated once.
- Counter, latches and FSM stay in bus_arbiter.

Test Plan:
- Single read: req_read_q[2]=1, addr 0x100. Memory answers mem_read_dn=1 with 0xDEADBEEF two cycles after strobe. Expect: grant=0100 one cycle after request, mem_addr=0x100, read_dn[2] pulses one cycle after mem_read_dn, rd_data=0xDEADBEEF.
- Fairness: all 4 requesters assert reads continuously, and memory answers immediately. Expect grant order 0,1,2,3,0 and each transaction 3 cycles. bus_busy=1110 while 0 owns the port.
- Timeout: TIMEOUT=8, write from requester 1 with no mem_write_dn. Expect mem_write_q held 8 WAIT cycles, then dropped, err[1] pulses, write_dn[1] stays 0, next grant possible.
- Halt: halt_q=1 with req_write_q[3]=1. Expect no grant for 10 cycles. On halt_q=0, grant=1000 next cycle and mem_data_out equals req_data slice 3.
- Both read and write from requester 0. Expect the read is serviced first, then the write granted after DONE if no other requests are pending.
- Reset mid-WAIT: drive rst=0 for one cycle during a read. Expect grant, strobes and pulses all 0 next cycle, state IDLE, ptr 0, no read_dn.
